// File: rtl/ada4355_frame_align_if.sv
// Word stream between the LVDS deserializers and the aligner, plus the aligned sample output.
// Valid-only stream with no backpressure: a word or sample is transferred on every rising clk edge where its valid is high.
interface ada4355_frame_align_if;
  logic        in_valid;
  logic [7:0]  frame_word;
  logic [7:0]  da_word;
  logic [7:0]  db_word;
  logic [15:0] adc_data;
  logic        adc_valid;

  modport master (
    output in_valid, frame_word, da_word, db_word,
    input  adc_data, adc_valid
  );

  modport slave (
    input  in_valid, frame_word, da_word, db_word,
    output adc_data, adc_valid
  );
endinterface

// File: rtl/ada4355_frame_align.sv
// ADA4355 word aligner: bit-slides the frame lane to FRAME_PATTERN and interleaves lanes A/B into samples.
// Optional feature macro ADA4355_ALIGN_ERRCNT_EN adds the err_count lock-loss counter output.
module ada4355_frame_align #(
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         LOCK_COUNT    = 4,
  parameter int         MISS_LIMIT    = 2,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        align_en,
  ada4355_frame_align_if.slave bus,
  output logic        locked,
  output logic [2:0]  shift_cnt,
`ifdef ADA4355_ALIGN_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N   = 4'(MISS_LIMIT);
  localparam logic [2:0] SETTLE_N = 3'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  shift_q, shift_d;
  logic [2:0]  settle_q, settle_d;
  logic [3:0]  hit_q, hit_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  prev_f_q, prev_a_q, prev_b_q;
  logic [15:0] adc_data_q, adc_data_d;
  logic        adc_valid_q, adc_valid_d;
  logic        locked_q, locked_d;
  logic [7:0]  w_f, w_a, w_b;
  logic [15:0] mix;
  logic        match;

  // Window of 8 bits starting shift_q bits back into the previous word.
  assign w_f   = 8'({prev_f_q, bus.frame_word} >> shift_q);
  assign w_a   = 8'({prev_a_q, bus.da_word}    >> shift_q);
  assign w_b   = 8'({prev_b_q, bus.db_word}    >> shift_q);
  assign match = (w_f == FRAME_PATTERN);

  always_comb begin
    mix = '0;
    for (int i = 0; i < 8; i++) begin
      mix[2*i]   = w_a[i];
      mix[2*i+1] = w_b[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    settle_d = settle_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (!align_en) begin
      state_d = ST_IDLE;
      hit_d   = '0;
      miss_d  = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SEARCH;
    end else if (bus.in_valid) begin
      if (settle_q != 3'd0) begin
        settle_d = settle_q - 3'd1;
      end else begin
        unique case (state_q)
          ST_SEARCH: begin
            if (match) begin
              hit_d   = 4'd1;
              state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
              miss_d  = '0;
            end else begin
              shift_d  = shift_q + 3'd1;
              settle_d = SETTLE_N;
            end
          end
          ST_VERIFY: begin
            if (match) begin
              hit_d = hit_q + 4'd1;
              if (hit_q + 4'd1 == LOCK_N) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              state_d  = ST_SEARCH;
              hit_d    = '0;
              shift_d  = shift_q + 3'd1;
              settle_d = SETTLE_N;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              miss_d = '0;
            end else if (miss_q + 4'd1 == MISS_N) begin
              // Lock lost: keep the current slide so it is retried first.
              state_d = ST_SEARCH;
              miss_d  = '0;
              hit_d   = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    locked_d    = (state_d == ST_LOCKED);
    adc_valid_d = bus.in_valid & locked_d;
    adc_data_d  = adc_valid_d ? mix : adc_data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      settle_q    <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      prev_f_q    <= '0;
      prev_a_q    <= '0;
      prev_b_q    <= '0;
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      settle_q    <= settle_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      adc_data_q  <= adc_data_d;
      adc_valid_q <= adc_valid_d;
      locked_q    <= locked_d;
      if (bus.in_valid) begin
        prev_f_q <= bus.frame_word;
        prev_a_q <= bus.da_word;
        prev_b_q <= bus.db_word;
      end
    end
  end

`ifdef ADA4355_ALIGN_ERRCNT_EN
  logic [15:0] err_q;

  // Counts only LOCKED->SEARCH losses; align_en does not clear it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= '0;
    end else if (state_q == ST_LOCKED && state_d == ST_SEARCH && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

  assign bus.adc_data  = adc_data_q;
  assign bus.adc_valid = adc_valid_q;
  assign locked        = locked_q;
  assign shift_cnt     = shift_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_ada4355_frame_align.sv
// Directed bench for ada4355_frame_align: aligned/slid streams, lock loss and relock, stuck frame, async reset.
// Build with +define+ADA4355_ALIGN_ERRCNT_EN to also check err_count.
module tb_ada4355_frame_align;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        align_en;
  logic        locked;
  logic [2:0]  shift_cnt;
  logic [1:0]  state_dbg;
`ifdef ADA4355_ALIGN_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  al_f[64];
  logic [15:0] al_s[64];
  logic        ev[64];

  ada4355_frame_align_if bus ();

  ada4355_frame_align dut (
    .clk         (clk),
    .resetn      (resetn),
    .align_en    (align_en),
    .bus         (bus),
    .locked      (locked),
    .shift_cnt   (shift_cnt),
`ifdef ADA4355_ALIGN_ERRCNT_EN
    .err_count   (err_count),
`endif
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] even_bits(input logic [15:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = s[2*i];
    return r;
  endfunction

  function automatic logic [7:0] odd_bits(input logic [15:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = s[2*i+1];
    return r;
  endfunction

  // Delivered word when the true word boundary sits s bits earlier than the deserializer's.
  function automatic logic [7:0] slide(input logic [7:0] cur, input logic [7:0] nxt, input int s);
    logic [15:0] t;
    t = {cur, nxt} << s;
    return t[15:8];
  endfunction

  task automatic step(input logic v, input logic [7:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic exp_v, input logic [15:0] exp_s);
    bus.in_valid   = v;
    bus.frame_word = f;
    bus.da_word    = a;
    bus.db_word    = b;
    if (exp_v) exp_q.push_back(exp_s);
    @(posedge clk);
    #1;
    chk("adc_valid", {31'd0, bus.adc_valid}, {31'd0, exp_v});
    if (bus.adc_valid === 1'b1) begin
      if (exp_q.size() != 0) begin
        chk("adc_data", {16'd0, bus.adc_data}, {16'd0, exp_q.pop_front()});
      end else begin
        checks++;
        errors++;
        $error("FAIL sb_empty: observed=%0h expected=none", bus.adc_data);
      end
    end
  endtask

  task automatic fill(input logic [15:0] fixed, input logic rnd);
    for (int k = 0; k < 64; k++) begin
      al_f[k] = 8'hF0;
      al_s[k] = rnd ? 16'($urandom_range(0, 65535)) : fixed;
      ev[k]   = 1'b0;
    end
  endtask

  task automatic set_ev(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) ev[k] = 1'b1;
  endtask

  task automatic run_words(input int s, input int lo, input int hi);
    for (int k = lo; k < hi; k++)
      step(1'b1, slide(al_f[k], al_f[k+1], s),
           slide(even_bits(al_s[k]), even_bits(al_s[k+1]), s),
           slide(odd_bits(al_s[k]), odd_bits(al_s[k+1]), s),
           ev[k], al_s[k]);
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000);
  endtask

  initial begin
    resetn         = 1'b0;
    align_en       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.frame_word = '0;
    bus.da_word    = '0;
    bus.db_word    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_valid", {31'd0, bus.adc_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.adc_data}, 32'd0);
    chk("rst_shift", {29'd0, shift_cnt}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    // Aligned stream of 16'h1234: locks on the 4th valid word.
    align_en = 1'b1;
    idle_step();
    chk("A_search", {30'd0, state_dbg}, {30'd0, S_SEARCH});
    fill(16'h1234, 1'b0);
    set_ev(3, 7);
    run_words(0, 0, 3);
    chk("A_not_locked", {31'd0, locked}, 32'd0);
    run_words(0, 3, 8);
    chk("A_locked", {31'd0, locked}, 32'd1);
    chk("A_shift", {29'd0, shift_cnt}, 32'd0);
    chk("A_data", {16'd0, bus.adc_data}, 32'h1234);

    align_en = 1'b0;
    idle_step();
    chk("off_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    chk("off_locked", {31'd0, locked}, 32'd0);
    chk("off_shift", {29'd0, shift_cnt}, 32'd0);
    chk("off_hold", {16'd0, bus.adc_data}, 32'h1234);

    // Slide of 5: reaches VERIFY at shift 5 on word 10, then async reset.
    align_en = 1'b1;
    idle_step();
    fill(16'h0000, 1'b1);
    run_words(5, 0, 11);
    chk("D_state", {30'd0, state_dbg}, {30'd0, S_VERIFY});
    chk("D_shift", {29'd0, shift_cnt}, 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("D_locked", {31'd0, locked}, 32'd0);
    chk("D_valid", {31'd0, bus.adc_valid}, 32'd0);
    chk("D_data", {16'd0, bus.adc_data}, 32'd0);
    chk("D_shift0", {29'd0, shift_cnt}, 32'd0);
    chk("D_state0", {30'd0, state_dbg}, {30'd0, S_IDLE});
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
`ifdef ADA4355_ALIGN_ERRCNT_EN
    chk("err_rst", {16'd0, err_count}, 32'd0);
`endif

    // Slide of 3 with random samples; single miss tolerated, three double misses drop lock.
    idle_step();
    fill(16'h0000, 1'b1);
    al_f[14] = 8'hE0;
    al_f[16] = 8'hE0; al_f[17] = 8'hE0;
    al_f[24] = 8'hE0; al_f[25] = 8'hE0;
    al_f[32] = 8'hE0; al_f[33] = 8'hE0;
    set_ev(9, 16);
    set_ev(21, 24);
    set_ev(29, 32);
    set_ev(37, 39);
    run_words(3, 0, 17);
    chk("B_single_miss", {31'd0, locked}, 32'd1);
    chk("B_shift", {29'd0, shift_cnt}, 32'd3);
    run_words(3, 17, 18);
    chk("B_lost", {31'd0, locked}, 32'd0);
    chk("B_lost_state", {30'd0, state_dbg}, {30'd0, S_SEARCH});
    chk("B_lost_shift", {29'd0, shift_cnt}, 32'd3);
    run_words(3, 18, 22);
    chk("B_relock", {31'd0, locked}, 32'd1);
    chk("B_relock_shift", {29'd0, shift_cnt}, 32'd3);
    run_words(3, 22, 40);
    chk("B_end_locked", {31'd0, locked}, 32'd1);
`ifdef ADA4355_ALIGN_ERRCNT_EN
    chk("err_three", {16'd0, err_count}, 32'd3);
`endif
    align_en = 1'b0;
    idle_step();
    align_en = 1'b1;
    idle_step();
`ifdef ADA4355_ALIGN_ERRCNT_EN
    chk("err_kept", {16'd0, err_count}, 32'd3);
`endif

    // Frame stuck at 0: slide advances every other word from 3 and wraps, never locks.
    for (int k = 0; k < 18; k++) begin
      step(1'b1, 8'h00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 16'h0000);
      chk("C_shift", {29'd0, shift_cnt}, 32'((3 + k / 2 + 1) % 8));
    end
    chk("C_locked", {31'd0, locked}, 32'd0);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
